// File: rtl/i281_loader_pkg.sv
// Shared types and constants for the i281 code-memory loader.
package i281_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    HI,
    LO,
    WRITE,
    CSUM,
    DONE,
    ERR
  } state_t;

  localparam int unsigned DEFAULT_TIMEOUT = 1000000;

  // Largest legal word count in a frame header: the whole code memory.
  function automatic int unsigned max_words(input int unsigned addr_w);
    return 32'd1 << addr_w;
  endfunction

endpackage

// File: rtl/i281_loader_timeout.sv
// Idle-cycle counter: counts while enabled, holds at TIMEOUT-1 and flags expiry.
module i281_loader_timeout
  import i281_loader_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] count;

  assign expired = enable && (count == LAST);

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values, independent of block ordering.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/i281_code_loader.sv
// Framed byte-stream loader that writes 16-bit instructions into i281 code memory
// from address 0 and releases the CPU only after a verified XOR checksum.
module i281_code_loader
  import i281_loader_pkg::*;
#(
  parameter int unsigned ADDR_W  = 6,
  parameter int unsigned INSTR_W = 16,
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               load_req,
  input  logic               rx_valid,
  input  logic [7:0]         rx_data,
  output logic               rx_ready,
  output logic               cm_we,
  output logic [ADDR_W-1:0]  cm_addr,
  output logic [INSTR_W-1:0] cm_wdata,
  output logic               run,
  output logic               busy,
  output logic               done,
  output logic               error,
  output logic [ADDR_W:0]    words_loaded
);

  localparam int unsigned MAX_N = max_words(ADDR_W);

  state_t          state;
  state_t          nxt;
  logic [7:0]      hi_byte;
  logic [7:0]      csum;
  logic [ADDR_W:0] remaining;
  logic            accept;
  logic            hdr_ok;
  logic            expired;

  assign accept = rx_valid && rx_ready;
  assign hdr_ok = (rx_data != 8'd0) && (32'(rx_data) <= MAX_N);

  // rx_ready is high exactly in the states that wait on the stream.
  i281_loader_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clock   (clock),
    .reset   (reset),
    .clear   (accept || !rx_ready),
    .enable  (rx_ready),
    .expired (expired)
  );

  // NOTE: every variable driven here gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    nxt = state;
    case (state)
      IDLE, DONE, ERR: if (load_req) nxt = HDR;
      HDR: begin
        if (accept)       nxt = hdr_ok ? HI : ERR;
        else if (expired) nxt = ERR;
      end
      HI: begin
        if (accept)       nxt = LO;
        else if (expired) nxt = ERR;
      end
      LO: begin
        if (accept)       nxt = WRITE;
        else if (expired) nxt = ERR;
      end
      WRITE: nxt = (remaining == (ADDR_W+1)'(1)) ? CSUM : HI;
      CSUM: begin
        if (accept)       nxt = (rx_data == csum) ? DONE : ERR;
        else if (expired) nxt = ERR;
      end
      default: nxt = IDLE;
    endcase
  end

  // NOTE: all datapath registers here are reset, so outputs are defined
  // from the moment reset is released (there is no memory array to exclude).
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      rx_ready     <= 1'b0;
      busy         <= 1'b0;
      error        <= 1'b0;
      done         <= 1'b0;
      run          <= 1'b0;
      cm_we        <= 1'b0;
      cm_addr      <= '0;
      cm_wdata     <= '0;
      words_loaded <= '0;
      remaining    <= '0;
      hi_byte      <= '0;
      csum         <= '0;
    end else begin
      state    <= nxt;
      rx_ready <= nxt inside {HDR, HI, LO, CSUM};
      busy     <= nxt inside {HDR, HI, LO, WRITE, CSUM};
      error    <= (nxt == ERR);
      done     <= (state == CSUM) && (nxt == DONE);
      cm_we    <= (nxt == WRITE);

      if (nxt == HDR && state != HDR) begin
        run          <= 1'b0;
        words_loaded <= '0;
      end else if (state == CSUM && nxt == DONE) begin
        run <= 1'b1;
      end

      case (state)
        HDR: if (accept) begin
          remaining <= (ADDR_W+1)'(rx_data);
          cm_addr   <= '0;
          csum      <= '0;
        end
        HI: if (accept) begin
          hi_byte <= rx_data;
          csum    <= csum ^ rx_data;
        end
        LO: if (accept) begin
          cm_wdata <= INSTR_W'({hi_byte, rx_data});
          csum     <= csum ^ rx_data;
        end
        WRITE: begin
          cm_addr      <= cm_addr + 1'b1;
          remaining    <= remaining - 1'b1;
          words_loaded <= words_loaded + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_i281_code_loader.sv
// Directed bench for i281_code_loader: a frame-level model predicts every
// code-memory write, and literal expectations pin the status outputs.
module tb_i281_code_loader;

  localparam int ADDR_W  = 6;
  localparam int TIMEOUT = 16;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              load_req = 1'b0;
  logic              rx_valid = 1'b0;
  logic [7:0]        rx_data = 8'h00;
  logic              rx_ready;
  logic              cm_we;
  logic [ADDR_W-1:0] cm_addr;
  logic [15:0]       cm_wdata;
  logic              run;
  logic              busy;
  logic              done;
  logic              error;
  logic [ADDR_W:0]   words_loaded;

  i281_code_loader #(.ADDR_W(ADDR_W), .INSTR_W(16), .TIMEOUT(TIMEOUT)) dut (
    .clock        (clock),
    .reset        (reset),
    .load_req     (load_req),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .rx_ready     (rx_ready),
    .cm_we        (cm_we),
    .cm_addr      (cm_addr),
    .cm_wdata     (cm_wdata),
    .run          (run),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [15:0]       data;
  } wr_t;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          n_writes = 0;
  wr_t         exp_q[$];
  wr_t         e;
  logic [15:0] mem [0:(1<<ADDR_W)-1];
  logic [15:0] words[$];
  logic        prev_we = 1'b0;
  int          w0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Compare process: every write the DUT issues must be the next one the model predicts.
  always @(negedge clock) begin
    if (reset) begin
      check("we_single_cycle", 32'(cm_we & prev_we), 0);
      check("run_error_exclusive", 32'(run & error), 0);
      if (cm_we) begin
        n_writes++;
        mem[cm_addr] = cm_wdata;
        check("rx_ready_low_in_write", 32'(rx_ready), 0);
        check("write_expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("write_addr", 32'(cm_addr), 32'(e.addr));
          check("write_data", 32'(cm_wdata), 32'(e.data));
        end
      end
    end
    prev_we = cm_we;
  end

  function automatic logic [7:0] xor_of();
    logic [7:0] x = 8'h00;
    foreach (words[i]) x = x ^ words[i][15:8] ^ words[i][7:0];
    return x;
  endfunction

  // Called just after an edge; returns just after the edge that accepts the byte.
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    rx_valid = 1'b1;
    rx_data  = b;
    while (!rx_ready && n < 50) begin
      @(posedge clock); #1;
      n++;
    end
    if (!rx_ready) begin
      check("rx_ready_wait", 32'(rx_ready), 1);
      rx_valid = 1'b0;
      return;
    end
    @(posedge clock); #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [ADDR_W-1:0] a, input logic [15:0] w);
    exp_q.push_back(wr_t'{addr: a, data: w});
    send_byte(w[15:8]);
    send_byte(w[7:0]);
  endtask

  task automatic send_frame(input logic corrupt);
    send_byte(8'(words.size()));
    foreach (words[i]) send_word(ADDR_W'(i), words[i]);
    send_byte(xor_of() ^ (corrupt ? 8'h03 : 8'h00));
  endtask

  task automatic start_load();
    load_req = 1'b1;
    @(posedge clock); #1;
    load_req = 1'b0;
    check("hdr_rx_ready", 32'(rx_ready), 1);
    check("hdr_busy", 32'(busy), 1);
    check("hdr_run_low", 32'(run), 0);
  endtask

  task automatic step();
    @(posedge clock); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset and idle with a byte presented: nothing may move.
    repeat (3) step();
    check("rst_cm_addr", 32'(cm_addr), 0);
    reset    = 1'b1;
    rx_valid = 1'b1;
    rx_data  = 8'hA5;
    repeat (20) step();
    check("idle_run", 32'(run), 0);
    check("idle_rx_ready", 32'(rx_ready), 0);
    check("idle_error", 32'(error), 0);
    check("idle_busy", 32'(busy), 0);
    check("idle_cm_we", 32'(cm_we), 0);
    check("idle_cm_wdata", 32'(cm_wdata), 0);
    check("idle_words", 32'(words_loaded), 0);
    rx_valid = 1'b0;

    // Good two-word frame; 81^05^82^0A is 0C.
    words = '{16'h8105, 16'h820A};
    check("model_xor", 32'(xor_of()), 32'h0C);
    start_load();
    send_frame(1'b0);
    check("ok_done", 32'(done), 1);
    check("ok_run", 32'(run), 1);
    check("ok_error", 32'(error), 0);
    check("ok_words", 32'(words_loaded), 2);
    check("ok_busy", 32'(busy), 0);
    step();
    check("ok_done_pulse", 32'(done), 0);
    check("ok_run_held", 32'(run), 1);
    check("ok_mem0", 32'(mem[0]), 32'h8105);
    check("ok_mem1", 32'(mem[1]), 32'h820A);
    check("ok_nwrites", 32'(n_writes), 2);

    // Same frame with checksum 0F: fault, then recovery.
    start_load();
    send_frame(1'b1);
    check("bad_error", 32'(error), 1);
    check("bad_run", 32'(run), 0);
    check("bad_done", 32'(done), 0);
    check("bad_words", 32'(words_loaded), 2);
    check("bad_nwrites", 32'(n_writes), 4);
    words = '{16'h1234};
    start_load();
    check("recover_error_clr", 32'(error), 0);
    send_frame(1'b0);
    check("recover_done", 32'(done), 1);
    check("recover_run", 32'(run), 1);
    check("recover_words", 32'(words_loaded), 1);
    check("recover_mem0", 32'(mem[0]), 32'h1234);

    // Illegal headers: 00 and 41 (one past 64 words).
    w0 = n_writes;
    start_load();
    send_byte(8'h00);
    check("hdr0_error", 32'(error), 1);
    check("hdr0_words", 32'(words_loaded), 0);
    check("hdr0_run", 32'(run), 0);
    start_load();
    send_byte(8'h41);
    check("hdr41_error", 32'(error), 1);
    check("hdr41_rx_ready", 32'(rx_ready), 0);
    repeat (3) step();
    check("hdr_no_write", n_writes, w0);

    // Stall after the high byte: ERR on the 16th edge after acceptance.
    start_load();
    send_byte(8'h01);
    send_byte(8'h55);
    repeat (15) step();
    check("to_not_yet", 32'(error), 0);
    check("to_busy", 32'(busy), 1);
    step();
    check("to_error", 32'(error), 1);
    check("to_run", 32'(run), 0);
    check("to_words", 32'(words_loaded), 0);
    check("to_no_write", n_writes, w0);

    // Reset during the write cycle of word 3 of a 64-word frame.
    start_load();
    send_byte(8'h40);
    send_word(6'd0, 16'h0102);
    send_word(6'd1, 16'h0304);
    send_byte(8'h05);
    send_byte(8'h06);
    check("mid_we_before_rst", 32'(cm_we), 1);
    check("mid_addr_before_rst", 32'(cm_addr), 2);
    reset = 1'b0;
    #1;
    check("mid_rst_we", 32'(cm_we), 0);
    check("mid_rst_run", 32'(run), 0);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_rx_ready", 32'(rx_ready), 0);
    check("mid_rst_addr", 32'(cm_addr), 0);
    check("mid_rst_words", 32'(words_loaded), 0);
    check("mid_rst_pending", exp_q.size(), 0);
    rx_valid = 1'b1;
    rx_data  = 8'h77;
    step();
    reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      check("post_rst_rx_ready", 32'(rx_ready), 0);
    end
    rx_valid = 1'b0;
    check("post_rst_mem1", 32'(mem[1]), 32'h0304);
    words = '{16'hBEEF};
    start_load();
    send_frame(1'b0);
    check("post_rst_done", 32'(done), 1);
    check("post_rst_mem0", 32'(mem[0]), 32'hBEEF);
    repeat (3) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
